reg_snapshot: RTL and testbench
===============================

# reg_snapshot

Double-buffered snapshot of the CPU register file for the debug screen. It sits between the CPU register-file debug read port and the VGA text pipeline's `regAddr`/`regData` interface. Once per frame, during vertical sync, it copies all 32 registers into a shadow bank and then swaps banks. The display therefore shows one coherent register set per frame, with no tearing, and the CPU read port is only occupied for 32 cycles per frame.

## Interface

Parameters:

- `VSYNC_ACTIVE`, default 1'b0: active level of `vsync`. A capture is triggered on the transition into this level.

Ports:

- `clk` input 1: clock.
- `resetn` input 1: asynchronous, active-low reset.
- `vsync` input 1: vertical sync from the VGA signal unit.
- `snap_req` input 1: single-cycle manual capture request.
- `freeze` input 1: while high, bank swaps are suppressed and the displayed set stays fixed.
- `cpu_regAddr` output 5: register address to the CPU debug read port.
- `cpu_regData` input 32: register data from the CPU. It is combinational with `cpu_regAddr` and valid in the same cycle.
- `vga_regAddr` input 5: register address from the text pipeline.
- `vga_regData` output 32: register data to the text pipeline.
- `busy` output 1: high while a capture is in progress.
- `snap_cnt` output 8: count of completed bank swaps.

## Operation

- Storage is two banks of 32 × 32 bits, bank0 and bank1. A 1-bit `active` flag selects the displayed bank; the other bank is the shadow.
- `vga_regData = bank[active][vga_regAddr]`. This is combinational with no latency, matching the text pipeline's same-cycle read.
- Trigger event (T): `vsync` is sampled into `vsync_q`. T = (`vsync == VSYNC_ACTIVE` && `vsync_q != VSYNC_ACTIVE`) || `snap_req`.
- FSM states:
  - IDLE:
    - `busy` = 0, `cpu_regAddr` = 0.
    - On T with `freeze` = 0: counter `cnt` <= 0 and go to CAPTURE.
    - On T with `freeze` = 1: ignore T and stay in IDLE.
  - CAPTURE:
    - `busy` = 1, `cpu_regAddr` = `cnt`.
    - Each cycle: shadow[`cnt`] <= `cpu_regData` and `cnt` <= `cnt` + 1.
    - In the cycle where `cnt` == 31: write the last word and go to SWAP.
    - T in this state is ignored and is not queued.
  - SWAP (one cycle):
    - `busy` = 1, `cpu_regAddr` = 0.
    - If `freeze` = 0: `active` <= ~`active` and `snap_cnt` <= `snap_cnt` + 1.
    - If `freeze` = 1: no swap, no increment, and the shadow contents are discarded (overwritten by the next capture).
    - Go to IDLE.
- `snap_cnt` is 8-bit modular: 255 → 0.
- `vsync` and `snap_req` asserted in the same cycle produce exactly one capture.
- Reset is asynchronous and can occur mid-capture: FSM → IDLE, `cnt` = 0, `active` = 0, `snap_cnt` = 0, both banks cleared to 0, `vsync_q` = ~`VSYNC_ACTIVE`.
  - Consequently, a `vsync` held at its active level through reset release triggers one capture in the first cycle after release.
- Register 0 is captured like any other register; no special case.

## Timing

- Reset values: `cpu_regAddr` = 0, `vga_regData` = 0 (all banks zero), `busy` = 0, `snap_cnt` = 0.
- Latency from T (cycle t, IDLE) to completion:
  - Cycle t+1: CAPTURE begins with `cpu_regAddr` = 0.
  - Cycles t+1 … t+32: registers 0–31 captured.
  - Cycle t+33: SWAP.
  - Cycle t+34: new data visible on `vga_regData`, and `snap_cnt` updated.
- `busy` is high for exactly 33 cycles (t+1 … t+33).
- A full cycle is 34 cycles from trigger to IDLE. This fits inside any vsync pulse of at least 34 clocks, so the swap never lands in the active video area.
- `vga_regData` changes only on the clock edge ending SWAP; it never changes during CAPTURE.

## Test plan

- Reset then idle:
  - Stimulus: hold `resetn` = 0, release, keep `vsync` inactive, CPU register r = 32'h1000_0000 + r.
  - Required: `vga_regData` = 0 for every address, `busy` = 0, `snap_cnt` = 0, `cpu_regAddr` = 0.
- vsync capture:
  - Stimulus: one `vsync` transition into `VSYNC_ACTIVE`, same CPU register pattern.
  - Required: `busy` high for 33 cycles; `cpu_regAddr` steps 0…31 on cycles t+1…t+32; from t+34, `vga_regAddr` = 5 reads 32'h1000_0005; `snap_cnt` = 1.
- No tearing:
  - Stimulus: after the first snapshot, change the CPU pattern to 32'hDEAD_0000 + r and trigger again; read `vga_regAddr` = 31 every cycle.
  - Required: 32'h1000_001F through cycle t+33, then 32'hDEAD_001F from cycle t+34.
- Freeze:
  - Stimulus (case A): assert `freeze` before a vsync edge. Required: no capture, `busy` stays 0.
  - Stimulus (case B): assert `freeze` at cycle t+10 of a capture. Required: the capture completes, but there is no swap, `snap_cnt` is unchanged, and the old data remains displayed.
- Collisions:
  - Stimulus: `snap_req` and the vsync edge in the same cycle, plus a second `snap_req` at t+5.
  - Required: exactly one capture and `snap_cnt` +1; the second request is dropped.
- Reset mid-capture and counter wrap:
  - Stimulus (case A): assert `resetn` = 0 at t+15. Required: all outputs return to their reset values immediately.
  - Stimulus (case B): run 256 captures. Required: `snap_cnt` wraps 255 → 0 and `active` returns to 0.

Source files
------------

// File: rtl/reg_snapshot.sv
// Double-buffered register-file snapshot for the debug text screen: copies the
// 32 CPU registers into the shadow bank once per frame, then swaps banks.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for a vsync edge or snap_req
// CAPTURE | reading register cnt from the CPU into the shadow bank
// SWAP    | one cycle; flips the displayed bank unless frozen
module reg_snapshot #(
  parameter logic VSYNC_ACTIVE = 1'b0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        vsync,
  input  logic        snap_req,
  input  logic        freeze,
  output logic [4:0]  cpu_regAddr,
  input  logic [31:0] cpu_regData,
  input  logic [4:0]  vga_regAddr,
  output logic [31:0] vga_regData,
  output logic        busy,
  output logic [7:0]  snap_cnt
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_SWAP    = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic        active;
  logic        vsync_q;
  logic        trig;
  logic        start;
  logic        cap_en;
  logic        swap_en;
  logic [31:0] bank0 [32];
  logic [31:0] bank1 [32];

  assign trig = ((vsync == VSYNC_ACTIVE) && (vsync_q != VSYNC_ACTIVE)) || snap_req;

  always_comb begin
    state_nxt   = state;
    busy        = 1'b0;
    cpu_regAddr = 5'd0;
    start       = 1'b0;
    cap_en      = 1'b0;
    swap_en     = 1'b0;
    case (state)
      S_IDLE: begin
        if (trig && !freeze) begin
          start     = 1'b1;
          state_nxt = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        busy        = 1'b1;
        cpu_regAddr = cnt;
        cap_en      = 1'b1;
        if (cnt == 5'd31) state_nxt = S_SWAP;
      end
      S_SWAP: begin
        busy      = 1'b1;
        swap_en   = !freeze;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      vsync_q  <= ~VSYNC_ACTIVE;
      cnt      <= 5'd0;
      active   <= 1'b0;
      snap_cnt <= 8'd0;
    end else begin
      state   <= state_nxt;
      vsync_q <= vsync;
      if (start) cnt <= 5'd0;
      else if (cap_en) cnt <= cnt + 5'd1;
      if (swap_en) begin
        active   <= ~active;
        snap_cnt <= snap_cnt + 8'd1;
      end
    end
  end

  // The shadow is always the bank not currently displayed.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 32; i++) begin
        bank0[i] <= 32'd0;
        bank1[i] <= 32'd0;
      end
    end else if (cap_en) begin
      if (active) bank0[cnt] <= cpu_regData;
      else        bank1[cnt] <= cpu_regData;
    end
  end

  assign vga_regData = active ? bank1[vga_regAddr] : bank0[vga_regAddr];

endmodule

// File: tb/tb_reg_snapshot.sv
// Scoreboard bench for reg_snapshot: stimulus queues the expected outcome of
// each capture, a negedge monitor checks the read ports and every completion.
module tb_reg_snapshot;

  localparam logic VS_ACT = 1'b0;

  logic        clk;
  logic        resetn;
  logic        vsync;
  logic        snap_req;
  logic        freeze;
  logic [4:0]  cpu_regAddr;
  logic [31:0] cpu_regData;
  logic [4:0]  vga_regAddr;
  logic [31:0] vga_regData;
  logic        busy;
  logic [7:0]  snap_cnt;

  logic [31:0] cpu_base;
  bit          fix_addr;

  typedef struct {
    bit          swapped;
    logic [31:0] base;
    logic [7:0]  cnt;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] disp [32];
  logic [7:0]  model_cnt;
  int          vectors;
  int          errors;

  reg_snapshot #(.VSYNC_ACTIVE(VS_ACT)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .vsync       (vsync),
    .snap_req    (snap_req),
    .freeze      (freeze),
    .cpu_regAddr (cpu_regAddr),
    .cpu_regData (cpu_regData),
    .vga_regAddr (vga_regAddr),
    .vga_regData (vga_regData),
    .busy        (busy),
    .snap_cnt    (snap_cnt)
  );

  // CPU debug port: register r holds cpu_base + r, read combinationally.
  assign cpu_regData = cpu_base + {27'd0, cpu_regAddr};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: cycle-level port checks plus scoreboard pop on every completion.
  initial begin
    int   busy_len;
    bit   busy_prev;
    exp_t it;
    logic [4:0] exp_addr;
    busy_len  = 0;
    busy_prev = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        sb_q.delete();
        for (int r = 0; r < 32; r++) disp[r] = 32'd0;
        busy_len  = 0;
        busy_prev = 0;
      end else begin
        if (busy) begin
          busy_len++;
          exp_addr = (busy_len <= 32) ? 5'(busy_len - 1) : 5'd0;
        end else begin
          exp_addr = 5'd0;
        end
        chk("cpu_regAddr", {27'd0, cpu_regAddr}, {27'd0, exp_addr});
        if (!busy && busy_prev) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_capture", 32'd1, 32'd0);
          end else begin
            it = sb_q.pop_front();
            chk("busy_length", busy_len, 33);
            if (it.swapped)
              for (int r = 0; r < 32; r++) disp[r] = it.base + r;
            chk("snap_cnt", {24'd0, snap_cnt}, {24'd0, it.cnt});
          end
          busy_len = 0;
        end
        chk("vga_regData", vga_regData, disp[vga_regAddr]);
        busy_prev = busy;
      end
    end
  end

  initial begin
    vga_regAddr = 5'd0;
    forever begin
      @(posedge clk);
      #1;
      vga_regAddr = fix_addr ? 5'd31 : 5'($urandom_range(0, 31));
    end
  end

  task automatic expect_capture(input bit swap);
    exp_t it;
    if (swap) model_cnt = model_cnt + 8'd1;
    it.swapped = swap;
    it.base    = cpu_base;
    it.cnt     = model_cnt;
    sb_q.push_back(it);
  endtask

  task automatic trigger(input bit by_vsync, input bit by_snap, input bit exp_busy);
    @(posedge clk);
    #1;
    if (by_vsync) vsync = VS_ACT;
    if (by_snap) snap_req = 1'b1;
    @(posedge clk);
    #1;
    snap_req = 1'b0;
    chk("busy_at_t+1", {31'd0, busy}, {31'd0, exp_busy});
  endtask

  task automatic wait_done();
    for (int i = 0; i < 120; i++) begin
      @(posedge clk);
      #1;
      if (sb_q.size() == 0 && !busy) return;
    end
    chk("completion_timeout", 32'd1, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_cpu_regAddr"}, {27'd0, cpu_regAddr}, 32'd0);
    chk({tag, "_snap_cnt"}, {24'd0, snap_cnt}, 32'd0);
    chk({tag, "_vga_regData"}, vga_regData, 32'd0);
  endtask

  initial begin
    int kind;
    vectors   = 0;
    errors    = 0;
    model_cnt = 8'd0;
    fix_addr  = 0;
    resetn    = 1'b0;
    vsync     = ~VS_ACT;
    snap_req  = 1'b0;
    freeze    = 1'b0;
    cpu_base  = 32'h1000_0000;
    #1;
    check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_reset_outputs("idle");

    // vsync-triggered capture
    expect_capture(1);
    trigger(1, 0, 1);
    wait_done();
    vsync = ~VS_ACT;

    // new CPU data must not appear on register 31 before the swap
    fix_addr = 1;
    cpu_base = 32'hDEAD_0000;
    expect_capture(1);
    trigger(1, 0, 1);
    wait_done();
    vsync = ~VS_ACT;
    fix_addr = 0;

    // freeze before the vsync edge: no capture at all
    cpu_base = 32'h5555_0000;
    freeze   = 1'b1;
    trigger(1, 0, 0);
    repeat (40) @(posedge clk);
    #1;
    vsync = ~VS_ACT;
    repeat (2) @(posedge clk);
    #1;
    freeze = 1'b0;

    // freeze raised mid-capture: capture completes, swap suppressed
    expect_capture(0);
    trigger(0, 1, 1);
    repeat (9) @(posedge clk);
    #1;
    freeze = 1'b1;
    wait_done();
    freeze = 1'b0;

    // vsync edge + snap_req together, plus a late snap_req at t+5
    cpu_base = 32'h7777_0000;
    expect_capture(1);
    trigger(1, 1, 1);
    repeat (4) @(posedge clk);
    #1;
    snap_req = 1'b1;
    @(posedge clk);
    #1;
    snap_req = 1'b0;
    wait_done();
    repeat (40) @(posedge clk);
    #1;
    vsync = ~VS_ACT;

    // reset at t+15 of a capture, vsync held active through release
    cpu_base = 32'h9999_0000;
    expect_capture(1);
    trigger(0, 1, 1);
    repeat (14) @(posedge clk);
    #1;
    resetn = 1'b0;
    vsync  = VS_ACT;
    #1;
    check_reset_outputs("midreset");
    repeat (3) @(posedge clk);
    #1;
    resetn    = 1'b1;
    model_cnt = 8'd0;
    expect_capture(1);
    @(posedge clk);
    #1;
    chk("busy_after_release", {31'd0, busy}, 32'd1);
    wait_done();
    vsync = ~VS_ACT;

    // 255 more swaps: snap_cnt wraps back to 0 and the bank flag returns to 0
    for (int n = 0; n < 255; n++) begin
      cpu_base = $urandom;
      kind = $urandom_range(0, 2);
      expect_capture(1);
      trigger(kind != 1, kind != 0, 1);
      wait_done();
      vsync = ~VS_ACT;
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    chk("snap_cnt_wrap", {24'd0, snap_cnt}, 32'd0);
    repeat (5) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
